uart_tx_arb: RTL
================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, meaning the number of byte-stream requesters (legal range 2..4).
REQ-002 SHALL have parameter MAX_BURST, default 16, meaning the maximum bytes per grant before a forced release (legal range 1..255).
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning the idle cycles inside a grant before a forced release (legal range 1..65535).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, the reset: asynchronous assert, active-low.
REQ-006 SHALL have port req_valid, input, NUM_REQ, one byte-valid bit per requester.
REQ-007 SHALL have port req_data, input, 8*NUM_REQ, the byte for requester i at bits [8i+7:8i].
REQ-008 SHALL have port req_last, input, NUM_REQ, marking the final byte of a packet.
REQ-009 SHALL have port req_ready, output, NUM_REQ, the per-requester byte accept.
REQ-010 SHALL have port tx_valid, output, 1, the byte-valid toward the UART transmitter.
REQ-011 SHALL have port tx_data, output, 8, the byte toward the UART transmitter.
REQ-012 SHALL have port tx_ready, input, 1, the UART transmitter accept.
REQ-013 SHALL have port grant_id, output, clog2(NUM_REQ), the index of the current owner.
REQ-014 SHALL have port busy, output, 1, high while a grant is held.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and LOCKED.
REQ-016 IDLE: if any req_valid is high, SHALL select the first valid requester searching upward (wrapping) from rr_ptr, register it into grant_id, and enter LOCKED on the next edge; arbitration latency is 1 cycle.
REQ-017 IDLE: SHALL drive tx_valid=0 and req_ready all 0.
REQ-018 LOCKED: tx_valid SHALL equal req_valid[grant_id], tx_data SHALL equal the granted byte, and req_ready[grant_id] SHALL equal tx_ready, all combinational with zero-cycle pass-through.
REQ-019 LOCKED: req_ready SHALL be 0 for all non-granted requesters.
REQ-020 A transfer SHALL occur when tx_valid and tx_ready are both high; each transfer increments the 8-bit burst_cnt.
REQ-021 Release SHALL happen on the edge after a transfer with req_last=1, or after a transfer that makes burst_cnt equal MAX_BURST, or when idle_cnt reaches TIMEOUT.
REQ-022 On any release the FSM SHALL return to IDLE, set rr_ptr=(grant_id+1) mod NUM_REQ, and clear burst_cnt and idle_cnt.
REQ-023 The 16-bit idle_cnt SHALL increment on each LOCKED cycle with req_valid[grant_id]=0 and SHALL clear on every transfer or when req_valid[grant_id]=1.
REQ-024 If last and MAX_BURST coincide on the same transfer, there SHALL be a single release (no double pointer advance).
REQ-025 busy SHALL be 1 exactly in LOCKED.
REQ-026 grant_id SHALL hold its value in IDLE.
REQ-027 Requesters SHALL hold data and last stable while valid is high and ready is low; the block does not buffer bytes.
REQ-028 IDLE always costs one bubble cycle; back-to-back packets from different requesters therefore have a 1-cycle gap.

Reset
REQ-029 rst_n=0 SHALL asynchronously force IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, and idle_cnt=0.
REQ-030 As a result, during reset tx_valid=0, req_ready=0, and busy=0.
REQ-031 Reset asserted mid-packet SHALL abandon the grant, with no transfer on that cycle.
REQ-032 Deassertion SHALL take effect on the next clk edge with arbitration from requester 0.

Structure
REQ-033 The FSM state encoding and the MAX_BURST, TIMEOUT, and NUM_REQ defaults SHALL reside in the shared package uart_arb_pkg.
REQ-034 The round-robin selector SHALL be a combinational sub-module rr_pick (inputs: request vector and pointer; outputs: index and any-valid).

Verification
REQ-035 Reset with both requesters valid -> first grant after reset release is requester 0; tx_data equals req0 byte 0x41 two cycles after rst_n rises.
REQ-036 Both requesters continuously send 3-byte packets with last on byte 3 and tx_ready=1 -> grant order is 0,1,0,1 with a 1-cycle bubble between packets.
REQ-037 Requester 1 streams 40 bytes without last, MAX_BURST=16, and requester 0 is also valid -> a release occurs after the 16th byte and requester 0 is granted next.
REQ-038 Requester 0 is granted and then drops valid for TIMEOUT=8 cycles -> release on cycle 8 and busy=0.
REQ-039 tx_ready is held low for 5 cycles mid-packet -> tx_data is stable, burst_cnt does not advance, and there is no release.
REQ-040 rst_n is pulsed low on byte 2 of a packet -> tx_valid=0 immediately and the FSM is in IDLE.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, parameter
// defaults and the wrapping index helper used by the round-robin search.
package uart_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ   = 2;
    localparam int DEF_MAX_BURST = 16;
    localparam int DEF_TIMEOUT   = 1024;

    // (a + b) mod n for operands already below n.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of req_i searching upward
// from ptr_i with wrap-around.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N = DEF_NUM_REQ,
    parameter int W = $clog2(DEF_NUM_REQ)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    logic [W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise synthesis infers a latch.
        idx_o = '0;
        cand  = '0;
        for (int off = N - 1; off >= 0; off--) begin
            cand = W'(wrap_add(int'(ptr_i), off, N));
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter multiplexing NUM_REQ byte streams onto one UART
// transmitter; a grant is held per packet, burst limit or idle timeout.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_valid,
    output logic [7:0]                 tx_data,
    input  logic                       tx_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int          GW         = $clog2(NUM_REQ);
    localparam logic [7:0]  BURST_LAST = 8'(MAX_BURST - 1);
    localparam logic [15:0] IDLE_LAST  = 16'(TIMEOUT - 1);

    arb_state_e    state_q, state_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [7:0]    burst_q, burst_d;
    logic [15:0]   idle_q, idle_d;

    logic [GW-1:0] pick_idx;
    logic          pick_any;
    logic [GW-1:0] next_ptr;
    logic [7:0]    byte_sel;
    logic          valid_sel;
    logic          last_sel;
    logic          xfer;

    rr_pick #(
        .N (NUM_REQ),
        .W (GW)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        byte_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                byte_sel = req_data[8*i +: 8];
            end
        end
    end

    assign valid_sel = req_valid[grant_q];
    assign last_sel  = req_last[grant_q];
    assign next_ptr  = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        burst_d   = burst_q;
        idle_d    = idle_q;
        tx_valid  = 1'b0;
        req_ready = '0;
        xfer      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                tx_valid           = valid_sel;
                req_ready[grant_q] = tx_ready;
                xfer               = valid_sel & tx_ready;

                if (xfer) begin
                    burst_d = burst_q + 8'd1;
                    idle_d  = '0;
                end else if (valid_sel) begin
                    idle_d  = '0;
                end else begin
                    idle_d  = idle_q + 16'd1;
                end

                // Last byte, burst limit and timeout all funnel into one release.
                if ((xfer && (last_sel || burst_q == BURST_LAST)) ||
                    (!valid_sel && idle_q == IDLE_LAST)) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                    burst_d  = '0;
                    idle_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            burst_q  <= '0;
            idle_q   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples the pre-edge values, regardless of statement order.
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            burst_q  <= burst_d;
            idle_q   <= idle_d;
        end
    end

    assign tx_data  = byte_sel;
    assign grant_id = grant_q;
    assign busy     = (state_q == LOCKED);

endmodule
